// File: rtl/csa_tree_pipe.sv
// -----------------------------------------------------------------------------
// csa_tree_pipe
//   Pipelined 8-operand carry-save reduction tree. It sums eight W-bit unsigned
//   operands per accepted beat and accepts one beat per cycle at full
//   throughput. Four register stages of 3:2 counter rows reduce 8 rows to 2.
//   A fifth stage does the final carry-propagate add.
//
//   Ports
//     clk        rising-edge clock
//     rstN       asynchronous active-low reset
//     in_valid   beat on in_ops is valid
//     in_ready   tree can accept a beat this cycle
//     in_ops     8*W  operand k occupies bits [k*W +: W], unsigned
//     out_valid  out_sum holds a valid result
//     out_ready  consumer accepts out_sum this cycle
//     out_sum    W+3  sum of the eight operands of the matching beat
//
//   Contents
//     csa_counter32  single-bit 3:2 counter cell {carry,sum} = a+b+c
//     csa_row        one row of counter cells, carry row pre-shifted by 1
//     csa_tree_pipe  top level
// -----------------------------------------------------------------------------

// 3:2 counter cell: sum_o is popcount bit 0, carry_o is popcount bit 1.
module csa_counter32 (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// N-bit carry-save row built from counter cells. The carry row is returned
// already aligned, meaning column i's carry lands in bit i+1. The carry out of
// the top column is dropped: every row is W+3 bits wide and the total sum
// never reaches 2^(W+3), so that bit is always 0.
module csa_row #(
    parameter int unsigned N = 11
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] c_i,
    output logic [N-1:0] sum_o,
    output logic [N-1:0] carry_o
);
    logic [N-1:0] co;
    logic         unused_top_carry;

    for (genvar i = 0; i < N; i++) begin : g_bit
        csa_counter32 u_cell (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .c_i    (c_i[i]),
            .sum_o  (sum_o[i]),
            .carry_o(co[i])
        );
    end

    assign carry_o          = {co[N-2:0], 1'b0};
    assign unused_top_carry = co[N-1];
endmodule

module csa_tree_pipe #(
    parameter int unsigned W = 64
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*W-1:0] in_ops,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+2:0]   out_sum
);
    localparam int unsigned OUT_W = W + 3;

    typedef logic [OUT_W-1:0] row_t;

    // Pipeline control: the whole pipe advances together or stalls together.
    logic adv;

    // Operand rows, zero-extended to the result width.
    row_t op [8];

    // Stage next-state and registers.
    row_t s1_d [6];
    row_t s1_q [6];
    row_t s2_d [4];
    row_t s2_q [4];
    row_t s3_d [3];
    row_t s3_q [3];
    row_t s4_d [2];
    row_t s4_q [2];
    row_t out_sum_d;
    row_t out_sum_q;

    logic v1_q, v2_q, v3_q, v4_q, out_valid_q;

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

    for (genvar k = 0; k < 8; k++) begin : g_op
        assign op[k] = {3'b000, in_ops[k*W +: W]};
    end

    // S1: 8 -> 6
    csa_row #(.N(OUT_W)) u_s1a (
        .a_i(op[0]), .b_i(op[1]), .c_i(op[2]),
        .sum_o(s1_d[0]), .carry_o(s1_d[1])
    );
    csa_row #(.N(OUT_W)) u_s1b (
        .a_i(op[3]), .b_i(op[4]), .c_i(op[5]),
        .sum_o(s1_d[2]), .carry_o(s1_d[3])
    );
    assign s1_d[4] = op[6];
    assign s1_d[5] = op[7];

    // S2: 6 -> 4
    csa_row #(.N(OUT_W)) u_s2a (
        .a_i(s1_q[0]), .b_i(s1_q[1]), .c_i(s1_q[2]),
        .sum_o(s2_d[0]), .carry_o(s2_d[1])
    );
    csa_row #(.N(OUT_W)) u_s2b (
        .a_i(s1_q[3]), .b_i(s1_q[4]), .c_i(s1_q[5]),
        .sum_o(s2_d[2]), .carry_o(s2_d[3])
    );

    // S3: 4 -> 3
    csa_row #(.N(OUT_W)) u_s3 (
        .a_i(s2_q[0]), .b_i(s2_q[1]), .c_i(s2_q[2]),
        .sum_o(s3_d[0]), .carry_o(s3_d[1])
    );
    assign s3_d[2] = s2_q[3];

    // S4: 3 -> 2 (sum row, carry row)
    csa_row #(.N(OUT_W)) u_s4 (
        .a_i(s3_q[0]), .b_i(s3_q[1]), .c_i(s3_q[2]),
        .sum_o(s4_d[0]), .carry_o(s4_d[1])
    );

    // S5: carry-propagate add
    assign out_sum_d = s4_q[0] + s4_q[1];

    // Data registers move with adv whether or not the beat is valid, so a
    // bubble carries whatever was on in_ops. Only the valid bits qualify it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < 6; i++) s1_q[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) s2_q[i] <= '0;
            for (int unsigned i = 0; i < 3; i++) s3_q[i] <= '0;
            for (int unsigned i = 0; i < 2; i++) s4_q[i] <= '0;
            out_sum_q   <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned i = 0; i < 6; i++) s1_q[i] <= s1_d[i];
            for (int unsigned i = 0; i < 4; i++) s2_q[i] <= s2_d[i];
            for (int unsigned i = 0; i < 3; i++) s3_q[i] <= s3_d[i];
            for (int unsigned i = 0; i < 2; i++) s4_q[i] <= s4_d[i];
            out_sum_q   <= out_sum_d;
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            v4_q        <= v3_q;
            out_valid_q <= v4_q;
        end
    end
endmodule

// File: tb/tb_csa_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_csa_tree_pipe
//   Directed bench for csa_tree_pipe. It uses a W=8 instance for the pipeline
//   and handshake behaviour and a W=64 instance for the full-width corner
//   cases.
// -----------------------------------------------------------------------------
module tb_csa_tree_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;

    // W = 8 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_ops;
    logic [10:0] out_sum;

    // W = 64 instance
    logic         in_valid64, in_ready64, out_valid64, out_ready64;
    logic [511:0] in_ops64;
    logic [66:0]  out_sum64;

    csa_tree_pipe #(.W(8)) u_dut8 (
        .clk      (clk),
        .rstN     (rstN),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ops   (in_ops),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum)
    );

    csa_tree_pipe #(.W(64)) u_dut64 (
        .clk      (clk),
        .rstN     (rstN),
        .in_valid (in_valid64),
        .in_ready (in_ready64),
        .in_ops   (in_ops64),
        .out_valid(out_valid64),
        .out_ready(out_ready64),
        .out_sum  (out_sum64)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] exp_q [$];
    logic [63:0] beats [9];
    logic [10:0] exp2  [9];
    logic [63:0] bA, bB, bC, bD;
    logic        exp_rdy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3,
                                          input logic [7:0] b4, input logic [7:0] b5,
                                          input logic [7:0] b6, input logic [7:0] b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [10:0] ref8(input logic [63:0] ops);
        logic [10:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) s = s + 11'(ops[k*8 +: 8]);
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rstN        = 1'b0;
        in_valid    = 1'b0;
        in_ops      = '0;
        out_ready   = 1'b1;
        in_valid64  = 1'b0;
        in_ops64    = '0;
        out_ready64 = 1'b1;
        repeat (2) tick();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid64", out_valid64, 0);
        chk("rst_out_sum64", out_sum64, 0);
        rstN = 1'b1;
        tick();

        // Test 1: all 0xFF, result 2040 exactly five edges after accept
        in_valid = 1'b1;
        in_ops   = {8{8'hFF}};
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_latency_not_early", out_valid, 0);
            tick();
        end
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_sum", out_sum, 11'h7F8);
        tick();
        chk("t1_bubble_after", out_valid, 0);

        // Single set bit in the MSB of op7 gives 128
        in_valid = 1'b1;
        in_ops   = 64'h8000_0000_0000_0000;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t1_op7_msb_valid", out_valid, 1);
        chk("t1_op7_msb_sum", out_sum, 11'd128);
        tick();

        // Test 2: 1..8 then eight random beats back-to-back
        beats[0] = pack8(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        exp2[0]  = 11'd36;
        for (int i = 1; i < 9; i++) begin
            beats[i] = {$urandom, $urandom};
            exp2[i]  = ref8(beats[i]);
        end
        for (int c = 0; c < 14; c++) begin
            if (c < 9) begin
                in_valid = 1'b1;
                in_ops   = beats[c];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("t2_in_ready", in_ready, 1);
            tick();
            if (c >= 4 && c <= 12) begin
                chk("t2_out_valid", out_valid, 1);
                chk("t2_out_sum", out_sum, exp2[c-4]);
            end else begin
                chk("t2_out_idle", out_valid, 0);
            end
        end

        // Test 3: stall with three beats in flight
        bA = pack8(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00); // 255
        bB = {8{8'h01}};                                                       // 8
        bC = {8{8'h80}};                                                       // 1024
        bD = {8{8'h55}};                                                       // 680, offered while stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ops    = bA;
        tick();
        in_ops = bB;
        tick();
        in_ops = bC;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t3_stall_valid", out_valid, 1);
        chk("t3_stall_sum", out_sum, 11'd255);
        chk("t3_stall_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_ops   = bD;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_sum", out_sum, 11'd255);
            chk("t3_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_release_in_ready", in_ready, 1);
        tick();
        chk("t3_drain_b_valid", out_valid, 1);
        chk("t3_drain_b_sum", out_sum, 11'd8);
        tick();
        chk("t3_drain_c_valid", out_valid, 1);
        chk("t3_drain_c_sum", out_sum, 11'd1024);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_no_extra", out_valid, 0);
        end

        // Test 4: asynchronous reset with four beats in flight
        in_valid = 1'b1;
        in_ops   = bA;
        tick();
        in_ops = bB;
        tick();
        in_ops = bC;
        tick();
        in_ops = bD;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_pre_valid", out_valid, 1);
        chk("t4_pre_sum", out_sum, 11'd255);
        #2;
        rstN = 1'b0;
        #1;
        chk("t4_async_valid", out_valid, 0);
        chk("t4_async_sum", out_sum, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_no_stale", out_valid, 0);
        end

        // Test 5: in_valid toggling, random out_ready, scoreboard
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            if (out_valid) begin
                chk("t5_expected_present", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("t5_sum", out_sum, exp_q[0]);
            end
            in_valid  = (c % 2 == 0);
            in_ops    = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = ~out_valid | out_ready;
            chk("t5_in_ready", in_ready, exp_rdy);
            if (out_valid && out_ready) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(ref8(in_ops));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) begin
            if (out_valid) begin
                chk("t5_drain_sum", out_sum, exp_q[0]);
                void'(exp_q.pop_front());
            end
            tick();
        end
        chk("t5_all_drained", exp_q.size(), 0);
        tick();
        chk("t5_idle_after", out_valid, 0);

        // Test 6: W=64 full-width corners
        // 8 * (2^64 - 1) = 2^67 - 8
        in_valid64 = 1'b1;
        in_ops64   = '1;
        tick();
        in_ops64 = {1'b1, 511'b0};
        tick();
        in_valid64 = 1'b0;
        repeat (3) tick();
        chk("t6_all_ones_valid", out_valid64, 1);
        chk("t6_all_ones_sum", out_sum64, 67'h7_FFFF_FFFF_FFFF_FFF8);
        tick();
        chk("t6_op7_msb_valid", out_valid64, 1);
        chk("t6_op7_msb_sum", out_sum64, 67'h0_8000_0000_0000_0000);
        tick();
        chk("t6_idle", out_valid64, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
